// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and default widths for the register-file write arbiter.
package regwr_pkg;
  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd31;
endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between NUM_REQ requesters and the register-file write port.
interface regfile_write_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
);
  logic [NUM_REQ-1:0]                 req_valid;
  logic [NUM_REQ-1:0]                 req_lock;
  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]                 req_ready;
  logic                               hold;
  logic                               regWrite;
  logic [ADDR_WIDTH-1:0]              regAddr;
  logic [DATA_WIDTH-1:0]              writeData;
  logic                               locked;

  modport master (
    output req_valid, req_lock, req_addr, req_data, hold,
    input  req_ready, regWrite, regAddr, writeData, locked
  );
  modport slave (
    input  req_valid, req_lock, req_addr, req_data, hold,
    output req_ready, regWrite, regAddr, writeData, locked
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid bit at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PW      = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PW-1:0]      idx,
  output logic               any
);
  always_comb begin
    int jj;
    logic [PW-1:0] j;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    jj    = 0;
    j     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      jj = int'(ptr) + i;
      if (jj >= NUM_REQ) jj = jj - NUM_REQ;
      j = PW'(jj);
      if (!any && valid[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = j;
      end
    end
  end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin, burst-lockable arbiter for the single register-file write port.
// Optional REGWR_ZERO_REG_DROP_EN: accept but never write beats to address all-ones.
module regfile_write_arbiter
  import regwr_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = REG_DATA_W,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input logic                   clk,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t            state, state_nx;
  logic [PW-1:0]     rr_ptr, lock_id, lock_id_nx, gnt_idx;
  logic [NUM_REQ-1:0] cand, gnt;
  logic              gnt_any, accept, zero_drop;

  // While locked, only the owner is a candidate, so the picker ignores rr_ptr.
  always_comb begin
    cand = bus.req_valid;
    if (state == LOCKED) cand = bus.req_valid & (NUM_REQ'(1) << lock_id);
  end

  rr_pick #(.NUM_REQ(NUM_REQ), .PW(PW)) u_pick (
    .valid (cand),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  assign accept        = gnt_any & ~bus.hold & ~reset;
  assign bus.req_ready = accept ? gnt : '0;
  assign bus.locked    = (state == LOCKED);

`ifdef REGWR_ZERO_REG_DROP_EN
  assign zero_drop = &bus.req_addr[gnt_idx];
`else
  assign zero_drop = 1'b0;
`endif

  always_comb begin
    state_nx   = state;
    lock_id_nx = lock_id;
    if (accept) begin
      case (state)
        IDLE:   if (bus.req_lock[gnt_idx]) begin
                  state_nx   = LOCKED;
                  lock_id_nx = gnt_idx;
                end
        LOCKED: if (!bus.req_lock[gnt_idx]) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lock_id <= '0;
      rr_ptr  <= '0;
    end else begin
      state   <= state_nx;
      lock_id <= lock_id_nx;
      // Inside a burst gnt_idx is always lock_id, so rr_ptr stays put.
      if (accept) rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.regWrite  <= 1'b0;
      bus.regAddr   <= '0;
      bus.writeData <= '0;
    end else begin
      bus.regWrite <= accept & ~zero_drop;
      if (accept) begin
        bus.regAddr   <= bus.req_addr[gnt_idx];
        bus.writeData <= bus.req_data[gnt_idx];
      end
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes expected writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  regfile_write_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic v, input logic lk,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_valid[i] = v;
    bus.req_lock[i]  = lk;
    bus.req_addr[i]  = a;
    bus.req_data[i]  = d;
  endtask

  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{addr: a, data: d});
  endtask

  task automatic rdy(input string nm, input logic [N-1:0] r);
    @(negedge clk);
    check(nm, 64'(bus.req_ready), 64'(r));
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin : mon
    wr_t e;
    if (!reset && bus.regWrite) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write",
                 bus.regAddr, bus.writeData);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.regAddr), 64'(e.addr));
        check("wr_data", bus.writeData, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach end of test");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '1;
    bus.req_lock  = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.hold      = 1'b0;
    #12;
    check("rst_ready",  64'(bus.req_ready), 64'd0);
    check("rst_regwr",  64'(bus.regWrite),  64'd0);
    check("rst_locked", 64'(bus.locked),    64'd0);
    bus.req_valid = '0;
    cyc();
    reset = 1'b0;

    // Round-robin: all four valid, addresses 1..4
    for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, AW'(i + 1), 64'h1000 + 64'(i));
    for (int k = 0; k < 5; k++) begin
      rdy($sformatf("rr_grant%0d", k), N'(1) << (k % N));
      push(AW'(k % N + 1), 64'h1000 + 64'(k % N));
      cyc();
    end
    // rr_ptr = 1 now; this beat is killed by an asynchronous mid-cycle reset
    rdy("rr_grant5", 4'b0010);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("async_ready",  64'(bus.req_ready), 64'd0);
    check("async_regwr",  64'(bus.regWrite),  64'd0);
    check("async_addr",   64'(bus.regAddr),   64'd0);
    check("async_data",   bus.writeData,      64'd0);
    check("async_locked", 64'(bus.locked),    64'd0);
    bus.req_valid = '0;
    cyc();
    reset = 1'b0;

    // Single beat from req1 moves rr_ptr to 2
    drive(1, 1'b1, 1'b0, 5'd8, 64'h88);
    rdy("pre_lock", 4'b0010);
    push(5'd8, 64'h88);
    cyc();
    drive(1, 1'b0, 1'b0, 5'd0, 64'h0);

    // Locked burst from req2 with req0 waiting
    drive(0, 1'b1, 1'b0, 5'd9, 64'h99);
    drive(2, 1'b1, 1'b1, 5'd5, 64'hA5);
    rdy("burst_b0", 4'b0100);
    check("burst_lk0", 64'(bus.locked), 64'd0);
    push(5'd5, 64'hA5);
    cyc();
    drive(2, 1'b1, 1'b1, 5'd6, 64'hA6);
    rdy("burst_b1", 4'b0100);
    check("burst_lk1", 64'(bus.locked), 64'd1);
    push(5'd6, 64'hA6);
    cyc();
    drive(2, 1'b1, 1'b0, 5'd7, 64'hA7);
    rdy("burst_b2", 4'b0100);
    check("burst_lk2", 64'(bus.locked), 64'd1);
    push(5'd7, 64'hA7);
    cyc();
    // rr_ptr must be 3: with req0 and req3 valid, req3 wins
    drive(2, 1'b0, 1'b0, 5'd0, 64'h0);
    drive(3, 1'b1, 1'b0, 5'd10, 64'hBB);
    rdy("burst_ptr3", 4'b1000);
    check("burst_lk3", 64'(bus.locked), 64'd0);
    push(5'd10, 64'hBB);
    cyc();
    drive(3, 1'b0, 1'b0, 5'd0, 64'h0);
    rdy("burst_req0", 4'b0001);
    push(5'd9, 64'h99);
    cyc();
    drive(0, 1'b0, 1'b0, 5'd0, 64'h0);
    rdy("idle_gap", 4'b0000);
    cyc();

    // hold for 3 cycles with req1 valid
    bus.hold = 1'b1;
    drive(1, 1'b1, 1'b0, 5'd12, 64'hC1);
    for (int h = 0; h < 3; h++) begin
      rdy($sformatf("hold_ready%0d", h), 4'b0000);
      check($sformatf("hold_regwr%0d", h), 64'(bus.regWrite), 64'd0);
      cyc();
    end
    bus.hold = 1'b0;
    rdy("hold_release", 4'b0010);
    push(5'd12, 64'hC1);
    cyc();
    drive(1, 1'b0, 1'b0, 5'd0, 64'h0);

    // Zero register write (rr_ptr = 2, only req0 valid)
    drive(0, 1'b1, 1'b0, 5'd31, 64'hDEAD);
    rdy("zero_ready", 4'b0001);
`ifndef REGWR_ZERO_REG_DROP_EN
    push(5'd31, 64'hDEAD);
`endif
    cyc();
    drive(0, 1'b0, 1'b0, 5'd0, 64'h0);
    @(negedge clk);
`ifdef REGWR_ZERO_REG_DROP_EN
    check("zero_regwr", 64'(bus.regWrite), 64'd0);
`else
    check("zero_regwr", 64'(bus.regWrite), 64'd1);
`endif
    cyc();

    // Reset while locked (rr_ptr = 1): req1 locks, req0 waits
    drive(0, 1'b1, 1'b0, 5'd3, 64'h33);
    drive(1, 1'b1, 1'b1, 5'd4, 64'h44);
    rdy("rlk_grant", 4'b0010);
    cyc();
    check("rlk_locked", 64'(bus.locked), 64'd1);
    check("rlk_hold0", 64'(bus.req_ready), 64'b0010);
    #1 reset = 1'b1;
    #1;
    check("rlk_unlocked", 64'(bus.locked), 64'd0);
    check("rlk_ready_rst", 64'(bus.req_ready), 64'd0);
    cyc();
    reset = 1'b0;
    rdy("rlk_after", 4'b0001);
    check("rlk_locked_after", 64'(bus.locked), 64'd0);
    push(5'd3, 64'h33);
    cyc();
    bus.req_valid = '0;
    bus.req_lock  = '0;
    repeat (3) cyc();

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
